// File: rtl/cda_pll_pkg.sv
// Shared types and default parameters for the PLL lock detector.
package cda_pll_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } lock_state_t;

   localparam int CNT_W_DEF      = 16;
   localparam int TOL_DEF        = 2;
   localparam int LOCK_CNT_DEF   = 4;
   localparam int UNLOCK_CNT_DEF = 2;

endpackage

// File: rtl/cda_period_meter.sv
// Per-channel period meter: two-flop capture, rising-edge detect and a
// saturating tick counter that reports the period between rising edges.
module cda_period_meter import cda_pll_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             clear,
   input  logic             sig,
   output logic             rise,
   output logic             valid,
   output logic             sat,
   output logic [CNT_W-1:0] period
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             s;
   logic             d;
   logic [CNT_W-1:0] cnt;

   assign rise = s & ~d;

   always_ff @(posedge clk) begin
      if (reset) begin
         s      <= 1'b0;
         d      <= 1'b0;
         cnt    <= '0;
         valid  <= 1'b0;
         sat    <= 1'b0;
         period <= '0;
      end else begin
         s   <= sig;
         d   <= s;
         sat <= 1'b0;
         if (clear) begin
            cnt   <= '0;
            valid <= 1'b0;
         end else if (run) begin
            if (rise) begin
               cnt <= '0;
               // The first edge after arming only starts the measurement.
               if (valid) period <= cnt + 1'b1;
               else       valid  <= 1'b1;
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_MAX - 1'b1) begin
                  sat   <= 1'b1;
                  valid <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/cda_pll_lock_detect.sv
// PLL lock detector: compares divided-reference and feedback periods and
// tracks lock with separate acquire/release thresholds.
module cda_pll_lock_detect import cda_pll_pkg::*; #(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int TOL        = TOL_DEF,
   parameter int LOCK_CNT   = LOCK_CNT_DEF,
   parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             refclk_in,
   input  logic             fbclk_in,
   output logic             locked,
   output logic             lock_lost,
   output logic [CNT_W-1:0] ref_period,
   output logic [CNT_W-1:0] fb_period
);

   localparam logic [CNT_W:0] TOL_V     = (CNT_W+1)'(TOL);
   localparam logic [3:0]     LOCK_TH   = 4'(LOCK_CNT);
   localparam logic [3:0]     UNLOCK_TH = 4'(UNLOCK_CNT);

   lock_state_t    state, state_nxt;
   logic [3:0]     good_cnt, good_nxt;
   logic [3:0]     bad_cnt, bad_nxt;
   logic           lost_nxt;
   logic           run, clear;
   logic           ref_rise, ref_valid, ref_sat;
   logic           fb_rise, fb_valid, fb_sat;
   logic           cmp_stb;
   logic [CNT_W:0] diff;
   logic           evt_good, evt_bad;

   assign clear = (state == IDLE);
   assign run   = enable & ~clear;

   cda_period_meter #(.CNT_W(CNT_W)) u_ref_meter (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .clear  (clear),
      .sig    (refclk_in),
      .rise   (ref_rise),
      .valid  (ref_valid),
      .sat    (ref_sat),
      .period (ref_period)
   );

   cda_period_meter #(.CNT_W(CNT_W)) u_fb_meter (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .clear  (clear),
      .sig    (fbclk_in),
      .rise   (fb_rise),
      .valid  (fb_valid),
      .sat    (fb_sat),
      .period (fb_period)
   );

   // Strobe lands one cycle after the fb edge so both periods are settled.
   always_ff @(posedge clk) begin
      if (reset) cmp_stb <= 1'b0;
      else       cmp_stb <= run & fb_rise & fb_valid & ref_valid;
   end

   always_comb begin
      diff = '0;
      if (ref_period >= fb_period) diff = {1'b0, ref_period} - {1'b0, fb_period};
      else                         diff = {1'b0, fb_period} - {1'b0, ref_period};
   end

   // Saturation of either channel overrides a concurrent compare.
   assign evt_bad  = ref_sat | fb_sat | (cmp_stb & (diff > TOL_V));
   assign evt_good = ~(ref_sat | fb_sat) & cmp_stb & (diff <= TOL_V);

   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      bad_nxt   = bad_cnt;
      lost_nxt  = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
         good_nxt  = '0;
         bad_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = ACQUIRE;
               good_nxt  = '0;
               bad_nxt   = '0;
            end
            ACQUIRE: begin
               if (evt_bad) begin
                  good_nxt = '0;
               end else if (evt_good) begin
                  if (good_cnt + 4'd1 == LOCK_TH) begin
                     state_nxt = LOCKED;
                     good_nxt  = '0;
                     bad_nxt   = '0;
                  end else begin
                     good_nxt = good_cnt + 4'd1;
                  end
               end
            end
            LOCKED: begin
               if (evt_bad) begin
                  if (bad_cnt + 4'd1 == UNLOCK_TH) begin
                     state_nxt = ACQUIRE;
                     lost_nxt  = 1'b1;
                     good_nxt  = '0;
                     bad_nxt   = '0;
                  end else begin
                     bad_nxt = bad_cnt + 4'd1;
                  end
               end else if (evt_good) begin
                  bad_nxt = '0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         good_cnt  <= '0;
         bad_cnt   <= '0;
         locked    <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         state     <= state_nxt;
         good_cnt  <= good_nxt;
         bad_cnt   <= bad_nxt;
         locked    <= (state_nxt == LOCKED);
         lock_lost <= lost_nxt;
      end
   end

endmodule

// File: tb/tb_cda_pll_lock_detect.sv
// Directed bench for cda_pll_lock_detect with a narrow counter so the
// saturation path is reachable in a short run.
module tb_cda_pll_lock_detect;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         refclk_in;
   logic         fbclk_in;
   logic         locked;
   logic         lock_lost;
   logic [W-1:0] ref_period;
   logic [W-1:0] fb_period;

   int n_cmp = 0;
   int n_bad = 0;

   int ref_per = 10, ref_cur = 10, ref_ph = 9;
   bit ref_on  = 1'b0;
   int fb_per  = 10, fb_cur = 10, fb_ph = 9;
   int fb_alt_n = 0, fb_alt_per = 15;
   bit fb_on   = 1'b0;

   int lost_cnt  = 0;
   bit lock_seen = 1'b0;
   int lost_snap;
   bit got;

   cda_pll_lock_detect #(
      .CNT_W      (W),
      .TOL        (2),
      .LOCK_CNT   (4),
      .UNLOCK_CNT (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .refclk_in  (refclk_in),
      .fbclk_in   (fbclk_in),
      .locked     (locked),
      .lock_lost  (lock_lost),
      .ref_period (ref_period),
      .fb_period  (fb_period)
   );

   always #5 clk = ~clk;

   // One sample-clock step: advance both synthetic clocks at the falling edge.
   task automatic tick();
      @(negedge clk);
      if (ref_on) begin
         ref_ph = ref_ph + 1;
         if (ref_ph >= ref_cur) begin
            ref_ph  = 0;
            ref_cur = ref_per;
         end
         refclk_in = (ref_ph < ref_cur / 2);
      end else begin
         refclk_in = 1'b0;
      end
      if (fb_on) begin
         fb_ph = fb_ph + 1;
         if (fb_ph >= fb_cur) begin
            fb_ph = 0;
            if (fb_alt_n > 0) begin
               fb_cur   = fb_alt_per;
               fb_alt_n = fb_alt_n - 1;
            end else begin
               fb_cur = fb_per;
            end
         end
         fbclk_in = (fb_ph < fb_cur / 2);
      end else begin
         fbclk_in = 1'b0;
      end
      if (lock_lost === 1'b1) lost_cnt++;
      if (locked === 1'b1) lock_seen = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drop enable, silence both clocks, re-enable and start both in phase.
   task automatic restart(input int rp, input int fp);
      enable = 1'b0;
      ref_on = 1'b0;
      fb_on  = 1'b0;
      refclk_in = 1'b0;
      fbclk_in  = 1'b0;
      run(4);
      ref_per = rp;
      fb_per  = fp;
      enable  = 1'b1;
      run(3);
      ref_cur = rp; ref_ph = rp - 1;
      fb_cur  = fp; fb_ph  = fp - 1;
      fb_alt_n = 0;
      ref_on = 1'b1;
      fb_on  = 1'b1;
      tick();
   endtask

   // Lock is expected exactly 4*fp+3 sample edges after the common first edge.
   task automatic acquire(input int rp, input int fp, input string tag);
      restart(rp, fp);
      run(4 * fp + 2);
      chk({tag, "_prelock"}, locked, 0);
      tick();
      chk({tag, "_lock"}, locked, 1);
   endtask

   task automatic wait_lost(input int bound, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < bound && !hit; i++) begin
         tick();
         if (lock_lost === 1'b1) hit = 1'b1;
      end
   endtask

   task automatic wait_lock(input int bound, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < bound && !hit; i++) begin
         tick();
         if (locked === 1'b1) hit = 1'b1;
      end
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      refclk_in = 1'b0;
      fbclk_in  = 1'b0;
      run(3);
      chk("rst_locked", locked, 0);
      chk("rst_lost", lock_lost, 0);
      chk("rst_ref_period", ref_period, 0);
      chk("rst_fb_period", fb_period, 0);
      reset = 1'b0;
      run(2);

      // Matched 10-tick clocks.
      acquire(10, 10, "acq10");
      chk("acq10_ref_period", ref_period, 10);
      chk("acq10_fb_period", fb_period, 10);
      chk("acq10_no_lost", lost_cnt, 0);

      // A single long fb period is absorbed by hysteresis.
      fb_alt_per = 15;
      fb_alt_n   = 1;
      run(60);
      chk("hyst1_locked", locked, 1);
      chk("hyst1_no_lost", lost_cnt, 0);
      chk("hyst1_fb_period", fb_period, 10);

      // Two in a row release lock.
      fb_alt_n = 2;
      wait_lost(80, got);
      chk("hyst2_lost_seen", got, 1);
      chk("hyst2_unlocked", locked, 0);
      chk("hyst2_fb_period", fb_period, 15);
      tick();
      chk("hyst2_pulse_1cyc", lock_lost, 0);
      chk("hyst2_lost_cnt", lost_cnt, 1);
      wait_lock(100, got);
      chk("hyst2_relock", got, 1);

      // Enable drop exits quietly and holds the captured periods.
      lost_snap = lost_cnt;
      enable = 1'b0;
      tick();
      chk("en0_locked", locked, 0);
      run(5);
      chk("en0_no_lost", lost_cnt, lost_snap);
      chk("en0_ref_hold", ref_period, 10);
      chk("en0_fb_hold", fb_period, 10);
      acquire(10, 10, "reen");

      // Tolerance edge: |10-12| = 2 locks, |10-13| = 3 never does.
      acquire(10, 12, "tol12");
      chk("tol12_ref_period", ref_period, 10);
      chk("tol12_fb_period", fb_period, 12);
      restart(10, 13);
      lock_seen = 1'b0;
      run(150);
      chk("tol13_never_locked", lock_seen, 0);
      chk("tol13_fb_period", fb_period, 13);

      // Loss of feedback: saturation is mismatch 1, next bad compare unlocks.
      acquire(10, 10, "loss");
      lost_snap = lost_cnt;
      fb_on    = 1'b0;
      fbclk_in = 1'b0;
      run(90);
      chk("loss_sat_still_locked", locked, 1);
      chk("loss_sat_no_lost", lost_cnt, lost_snap);
      fb_per = 20; fb_cur = 20; fb_ph = 19;
      fb_on  = 1'b1;
      wait_lost(60, got);
      chk("loss_lost_seen", got, 1);
      chk("loss_unlocked", locked, 0);
      chk("loss_fb_period", fb_period, 20);
      tick();
      chk("loss_pulse_1cyc", lock_lost, 0);

      // One-cycle reset while locked.
      acquire(10, 10, "rst2");
      reset = 1'b1;
      tick();
      chk("rst2_locked", locked, 0);
      chk("rst2_lost", lock_lost, 0);
      chk("rst2_ref_period", ref_period, 0);
      chk("rst2_fb_period", fb_period, 0);
      reset = 1'b0;
      run(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
